bvurem_slt_eval: RTL

- Sequential reference evaluator for the bvslt/bvurem predicate family.
- Consumes an operand triple (x, s, t), computes r = x bvurem s with a bit-serial restoring divider, then computes slt = (r <s t).
- Sits directly downstream of the operand enumerator and alongside the combinational Skolem netlist, so the Skolem witness bit can be checked against the ground-truth predicate.

---
 rtl/bvurem_slt_eval_if.sv | 39 +++
 rtl/bvurem_slt_eval.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/bvurem_slt_eval_if.sv
// Operand/result bus for bvurem_slt_eval. Skolem-check signals exist only
// when BVUREM_SLT_MISMATCH_EN is defined.
interface bvurem_slt_eval_if #(
  parameter int W     = 4,
  parameter int CNT_W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_x;
  logic [W-1:0] in_s;
  logic [W-1:0] in_t;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_urem;
  logic         out_slt;
`ifdef BVUREM_SLT_MISMATCH_EN
  logic             sk_bit;
  logic             out_mismatch;
  logic [CNT_W-1:0] mismatch_cnt;
`endif

  modport master (
    output in_valid, in_x, in_s, in_t, out_ready,
    input  in_ready, out_valid, out_urem, out_slt
`ifdef BVUREM_SLT_MISMATCH_EN
    , output sk_bit
    , input  out_mismatch, mismatch_cnt
`endif
  );

  modport slave (
    input  in_valid, in_x, in_s, in_t, out_ready,
    output in_ready, out_valid, out_urem, out_slt
`ifdef BVUREM_SLT_MISMATCH_EN
    , input  sk_bit
    , output out_mismatch, mismatch_cnt
`endif
  );
endinterface

// File: rtl/bvurem_slt_eval.sv
// Bit-serial reference evaluator: r = x bvurem s, then slt = (r <s t).
// Optional Skolem mismatch checking is enabled by BVUREM_SLT_MISMATCH_EN.
module bvurem_slt_eval #(
  parameter int W     = 4,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bvurem_slt_eval_if.slave        bus,
  output logic [1:0]              dbg_state
);
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  s_q, s_d;
  logic [W-1:0]  t_q, t_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  urem_q, urem_d;
  logic          slt_q, slt_d;
  logic [W:0]    partial;
  logic [W-1:0]  r_fin;
`ifdef BVUREM_SLT_MISMATCH_EN
  logic             sk_q, sk_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;
`endif

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready is high only in IDLE; out_valid is high only in DONE and
  // out_urem/out_slt stay constant until the out transfer completes.
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_urem  = urem_q;
  assign bus.out_slt   = slt_q;
  assign dbg_state     = state_q;
`ifdef BVUREM_SLT_MISMATCH_EN
  assign bus.out_mismatch = mis_q;
  assign bus.mismatch_cnt = mcnt_q;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    s_d     = s_q;
    t_d     = t_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    urem_d  = urem_q;
    slt_d   = slt_q;
    r_fin   = '0;
`ifdef BVUREM_SLT_MISMATCH_EN
    sk_d    = sk_q;
    mis_d   = mis_q;
    mcnt_d  = mcnt_q;
`endif
    // The stored remainder is always < 2^W, so only the W+1-bit trial value
    // needs the extra bit; the compare against {0,s} can then never overflow.
    partial = {rem_q, x_q[W-1]};

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          x_d     = bus.in_x;
          s_d     = bus.in_s;
          t_d     = bus.in_t;
          rem_d   = '0;
          cnt_d   = CW'(W - 1);
          state_d = S_DIV;
`ifdef BVUREM_SLT_MISMATCH_EN
          sk_d    = bus.sk_bit;
`endif
        end
      end
      S_DIV: begin
        if (partial >= {1'b0, s_q}) begin
          rem_d = W'(partial - {1'b0, s_q});
        end else begin
          rem_d = partial[W-1:0];
        end
        x_d   = {x_q[W-2:0], 1'b0};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          r_fin   = rem_d;
          urem_d  = r_fin;
          slt_d   = ($signed(r_fin) < $signed(t_q));
          state_d = S_DONE;
`ifdef BVUREM_SLT_MISMATCH_EN
          mis_d   = sk_q ^ slt_d;
`endif
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
`ifdef BVUREM_SLT_MISMATCH_EN
          if (mis_q && (mcnt_q != {CNT_W{1'b1}})) begin
            mcnt_d = mcnt_q + 1'b1;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      s_q     <= '0;
      t_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      urem_q  <= '0;
      slt_q   <= 1'b0;
`ifdef BVUREM_SLT_MISMATCH_EN
      sk_q    <= 1'b0;
      mis_q   <= 1'b0;
      mcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      s_q     <= s_d;
      t_q     <= t_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      urem_q  <= urem_d;
      slt_q   <= slt_d;
`ifdef BVUREM_SLT_MISMATCH_EN
      sk_q    <= sk_d;
      mis_q   <= mis_d;
      mcnt_q  <= mcnt_d;
`endif
    end
  end
endmodule
